// File: rtl/confirm_pkg.sv
// Shared widths, field offsets, FSM state type and byte-masked key compare
// for the multi-channel confirmation engine.
package confirm_pkg;

    localparam int KWID     = 104;
    localparam int NCH      = 13;
    localparam int IDWID    = 8;
    localparam int DEP      = 1 << IDWID;
    localparam int PRIOR    = 8;
    localparam int MASKWID  = KWID / 8;
    localparam int SEGWID   = IDWID + 2;
    localparam int CFWID    = 1 + IDWID + PRIOR;
    localparam int TOTALWID = KWID + MASKWID + PRIOR;
    localparam int ENTWID   = TOTALWID + 1;
    localparam int CHWID    = $clog2(NCH);

    // compare-result segment fields
    localparam int SEG_VLD = IDWID + 1;
    localparam int SEG_HIT = IDWID;

    // rule string {key, mask, prio}; stored entry prepends the valid bit
    localparam int RS_KEY_LSB  = MASKWID + PRIOR;
    localparam int RS_MASK_LSB = PRIOR;
    localparam int RS_PRIO_LSB = 0;
    localparam int ENT_VLD     = TOTALWID;

    // confirm result {match, id, prio}
    localparam int CF_MATCH  = CFWID - 1;
    localparam int CF_ID_LSB = PRIOR;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // a set mask bit makes that key byte a don't-care
    function automatic logic byte_match(input logic [KWID-1:0]    key,
                                        input logic [KWID-1:0]    rkey,
                                        input logic [MASKWID-1:0] mask);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < MASKWID; b++) begin
            if (!mask[b] && (key[8*b +: 8] != rkey[8*b +: 8]))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/confirm_rule_ram.sv
// Rule store: one shared write port, NRD replicated banks each giving a
// synchronous read-first read port. No reset on the array.
module confirm_rule_ram
    import confirm_pkg::*;
#(
    parameter int NRD = NCH,
    parameter int AW  = IDWID,
    parameter int DW  = ENTWID
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata
);

    for (genvar g = 0; g < NRD; g++) begin : g_bank
        logic [DW-1:0] mem [0:(1<<AW)-1];
        logic [DW-1:0] rd_q;

        // nonblocking write and read in one block gives old data on a collision
        always_ff @(posedge clk) begin
            if (we)
                mem[waddr] <= wdata;
            rd_q <= mem[raddr[g*AW +: AW]];
        end

        assign rdata[g*DW +: DW] = rd_q;
    end

endmodule

// File: rtl/confirm_engine_mc.sv
// Multi-channel confirm engine: store init/clear FSM, rule set handling,
// 3-cycle search pipeline (read, byte-masked compare, two-level priority pick).
module confirm_engine_mc
    import confirm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [KWID-1:0]         i_Key,
    input  logic                    i_Valid,
    input  logic [NCH*SEGWID-1:0]   i_Compare_Result,
    output logic [NCH*CFWID-1:0]    o_Confirm_Result,
    output logic                    o_Valid,
    output logic                    o_Best_Valid,
    output logic [CHWID-1:0]        o_Best_Chan,
    output logic [CFWID-1:0]        o_Best_Result,
    input  logic [IDWID-1:0]        i_Set_Confirm_ID,
    input  logic [TOTALWID-1:0]     i_Set_Confirm_String,
    input  logic                    i_Set_Confirm_Enable,
    input  logic                    i_Set_Confirm_Op,
    input  logic                    i_Clear_All,
    output logic                    o_Busy,
    output logic                    o_Set_Ack,
    output logic                    o_Set_Err
);

    // state | meaning
    // INIT  | post-reset sweep writing every entry invalid, busy
    // IDLE  | store usable, sets accepted
    // CLEAR | requested sweep writing every entry invalid, busy

    localparam int NLO = (NCH + 1) / 2;

    state_t                 state;
    logic [IDWID-1:0]       clr_cnt;

    logic                   ram_we;
    logic [IDWID-1:0]       ram_waddr;
    logic [ENTWID-1:0]      ram_wdata;
    logic [NCH*IDWID-1:0]   rd_addr;
    logic [NCH*ENTWID-1:0]  rd_data;

    logic                   s1_valid;
    logic [KWID-1:0]        s1_key;
    logic [NCH*SEGWID-1:0]  s1_seg;

    logic [NCH*CFWID-1:0]   cf_next;
    logic [SEGWID-1:0]      seg;
    logic [ENTWID-1:0]      ent;
    logic                   s2_valid;
    logic [NCH*CFWID-1:0]   s2_cf;

    logic                   lo_vld, hi_vld;
    logic [CHWID-1:0]       lo_chan, hi_chan;
    logic [CFWID-1:0]       lo_cf, hi_cf;
    logic                   s3_valid;
    logic [NCH*CFWID-1:0]   s3_cf;
    logic                   s3_lo_vld, s3_hi_vld;
    logic [CHWID-1:0]       s3_lo_chan, s3_hi_chan;
    logic [CFWID-1:0]       s3_lo_cf, s3_hi_cf;
    logic                   pick_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            clr_cnt   <= '0;
            o_Set_Ack <= 1'b0;
            o_Set_Err <= 1'b0;
        end else begin
            o_Set_Ack <= 1'b0;
            o_Set_Err <= 1'b0;
            if (i_Set_Confirm_Enable) begin
                if (state == IDLE)
                    o_Set_Ack <= 1'b1;
                else
                    o_Set_Err <= 1'b1;
            end
            case (state)
                INIT, CLEAR: begin
                    if (clr_cnt == IDWID'(DEP - 1)) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (i_Clear_All) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= INIT;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    assign o_Busy = (state != IDLE);

    // sweep owns the write port while busy; sets are dropped then
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_cnt;
        ram_wdata = '0;
        if (state != IDLE) begin
            ram_we = 1'b1;
        end else if (i_Set_Confirm_Enable) begin
            ram_we    = 1'b1;
            ram_waddr = i_Set_Confirm_ID;
            ram_wdata = i_Set_Confirm_Op ? '0 : {1'b1, i_Set_Confirm_String};
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_raddr
        assign rd_addr[c*IDWID +: IDWID] = i_Compare_Result[c*SEGWID +: IDWID];
    end

    confirm_rule_ram #(
        .NRD (NCH),
        .AW  (IDWID),
        .DW  (ENTWID)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_key   <= '0;
            s1_seg   <= '0;
        end else begin
            s1_valid <= i_Valid;
            s1_key   <= i_Key;
            s1_seg   <= i_Compare_Result;
        end
    end

    always_comb begin
        cf_next = '0;
        seg     = '0;
        ent     = '0;
        for (int c = 0; c < NCH; c++) begin
            seg = s1_seg[c*SEGWID +: SEGWID];
            ent = rd_data[c*ENTWID +: ENTWID];
            if (seg[SEG_VLD] && seg[SEG_HIT] && ent[ENT_VLD] &&
                byte_match(s1_key, ent[RS_KEY_LSB +: KWID], ent[RS_MASK_LSB +: MASKWID]))
                cf_next[c*CFWID +: CFWID] = {1'b1, seg[IDWID-1:0], ent[RS_PRIO_LSB +: PRIOR]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_cf    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_cf    <= cf_next;
        end
    end

    // first reduction level: best of lower and upper channel halves,
    // strict greater-than keeps the lowest index on a tie
    always_comb begin
        lo_vld  = 1'b0;
        lo_chan = '0;
        lo_cf   = '0;
        hi_vld  = 1'b0;
        hi_chan = '0;
        hi_cf   = '0;
        for (int c = 0; c < NLO; c++) begin
            if (s2_cf[c*CFWID + CF_MATCH] &&
                (!lo_vld || (s2_cf[c*CFWID +: PRIOR] > lo_cf[PRIOR-1:0]))) begin
                lo_vld  = 1'b1;
                lo_chan = CHWID'(c);
                lo_cf   = s2_cf[c*CFWID +: CFWID];
            end
        end
        for (int c = NLO; c < NCH; c++) begin
            if (s2_cf[c*CFWID + CF_MATCH] &&
                (!hi_vld || (s2_cf[c*CFWID +: PRIOR] > hi_cf[PRIOR-1:0]))) begin
                hi_vld  = 1'b1;
                hi_chan = CHWID'(c);
                hi_cf   = s2_cf[c*CFWID +: CFWID];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_valid   <= 1'b0;
            s3_cf      <= '0;
            s3_lo_vld  <= 1'b0;
            s3_lo_chan <= '0;
            s3_lo_cf   <= '0;
            s3_hi_vld  <= 1'b0;
            s3_hi_chan <= '0;
            s3_hi_cf   <= '0;
        end else begin
            s3_valid   <= s2_valid;
            s3_cf      <= s2_cf;
            s3_lo_vld  <= lo_vld;
            s3_lo_chan <= lo_chan;
            s3_lo_cf   <= lo_cf;
            s3_hi_vld  <= hi_vld;
            s3_hi_chan <= hi_chan;
            s3_hi_cf   <= hi_cf;
        end
    end

    // upper half wins only on strictly higher priority
    assign pick_hi = s3_hi_vld &&
                     (!s3_lo_vld || (s3_hi_cf[PRIOR-1:0] > s3_lo_cf[PRIOR-1:0]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_Valid          <= 1'b0;
            o_Confirm_Result <= '0;
            o_Best_Valid     <= 1'b0;
            o_Best_Chan      <= '0;
            o_Best_Result    <= '0;
        end else begin
            o_Valid          <= s3_valid;
            o_Confirm_Result <= s3_cf;
            o_Best_Valid     <= s3_lo_vld | s3_hi_vld;
            o_Best_Chan      <= pick_hi ? s3_hi_chan : s3_lo_chan;
            o_Best_Result    <= pick_hi ? s3_hi_cf : s3_lo_cf;
        end
    end

endmodule

// File: tb/tb_confirm_engine_mc.sv
// Scoreboard bench for confirm_engine_mc: directed searches push expected
// results into a queue, a negedge monitor pops and compares on o_Valid.
module tb_confirm_engine_mc;
    import confirm_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [KWID-1:0]        i_Key;
    logic                   i_Valid;
    logic [NCH*SEGWID-1:0]  i_Compare_Result;
    logic [NCH*CFWID-1:0]   o_Confirm_Result;
    logic                   o_Valid;
    logic                   o_Best_Valid;
    logic [CHWID-1:0]       o_Best_Chan;
    logic [CFWID-1:0]       o_Best_Result;
    logic [IDWID-1:0]       i_Set_Confirm_ID;
    logic [TOTALWID-1:0]    i_Set_Confirm_String;
    logic                   i_Set_Confirm_Enable;
    logic                   i_Set_Confirm_Op;
    logic                   i_Clear_All;
    logic                   o_Busy;
    logic                   o_Set_Ack;
    logic                   o_Set_Err;

    typedef struct {
        logic [NCH*CFWID-1:0] cf;
        logic                 bv;
        logic [CHWID-1:0]     ch;
        logic [CFWID-1:0]     br;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   c0;
    int   guard;

    logic [KWID-1:0] k11, k22, k33, kx;
    localparam logic [NCH*CFWID-1:0] NO_CF = '0;
    localparam logic [CFWID-1:0]     NO_BR = '0;

    confirm_engine_mc dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_Key                (i_Key),
        .i_Valid              (i_Valid),
        .i_Compare_Result     (i_Compare_Result),
        .o_Confirm_Result     (o_Confirm_Result),
        .o_Valid              (o_Valid),
        .o_Best_Valid         (o_Best_Valid),
        .o_Best_Chan          (o_Best_Chan),
        .o_Best_Result        (o_Best_Result),
        .i_Set_Confirm_ID     (i_Set_Confirm_ID),
        .i_Set_Confirm_String (i_Set_Confirm_String),
        .i_Set_Confirm_Enable (i_Set_Confirm_Enable),
        .i_Set_Confirm_Op     (i_Set_Confirm_Op),
        .i_Clear_All          (i_Clear_All),
        .o_Busy               (o_Busy),
        .o_Set_Ack            (o_Set_Ack),
        .o_Set_Err            (o_Set_Err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CFWID-1:0] cfv(input int id, input int prio);
        logic [CFWID-1:0] r;
        r = {1'b1, id[IDWID-1:0], prio[PRIOR-1:0]};
        return r;
    endfunction

    function automatic logic [NCH*CFWID-1:0] put(input logic [NCH*CFWID-1:0] v, input int c,
                                                 input logic [CFWID-1:0] r);
        logic [NCH*CFWID-1:0] o;
        o = v;
        o[c*CFWID +: CFWID] = r;
        return o;
    endfunction

    function automatic logic [NCH*SEGWID-1:0] seg_at(input int c, input int id,
                                                     input logic vld, input logic hit);
        logic [NCH*SEGWID-1:0] v;
        v = '0;
        v[c*SEGWID +: SEGWID] = {vld, hit, id[IDWID-1:0]};
        return v;
    endfunction

    function automatic exp_t mk(input logic [NCH*CFWID-1:0] cf, input logic bv, input int ch,
                                input logic [CFWID-1:0] br);
        exp_t e;
        e.cf = cf;
        e.bv = bv;
        e.ch = ch[CHWID-1:0];
        e.br = br;
        return e;
    endfunction

    task automatic issue(input logic [KWID-1:0] key, input logic [NCH*SEGWID-1:0] segs, input exp_t e);
        i_Key            = key;
        i_Compare_Result = segs;
        i_Valid          = 1'b1;
        q.push_back(e);
    endtask

    task automatic search(input logic [KWID-1:0] key, input logic [NCH*SEGWID-1:0] segs, input exp_t e);
        @(negedge clk);
        issue(key, segs, e);
        @(negedge clk);
        i_Valid = 1'b0;
    endtask

    task automatic drive_set(input int id, input logic [KWID-1:0] key, input logic [MASKWID-1:0] mask,
                             input int prio, input logic op);
        i_Set_Confirm_ID     = id[IDWID-1:0];
        i_Set_Confirm_String = {key, mask, prio[PRIOR-1:0]};
        i_Set_Confirm_Op     = op;
        i_Set_Confirm_Enable = 1'b1;
    endtask

    task automatic do_set(input int id, input logic [KWID-1:0] key, input logic [MASKWID-1:0] mask,
                          input int prio, input logic exp_ack, input string tag);
        @(negedge clk);
        drive_set(id, key, mask, prio, 1'b0);
        @(negedge clk);
        i_Set_Confirm_Enable = 1'b0;
        check({tag, "_ack"}, 256'(o_Set_Ack), 256'(exp_ack));
        check({tag, "_err"}, 256'(o_Set_Err), 256'(!exp_ack));
    endtask

    always @(negedge clk) begin
        if (rst && o_Valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got o_Valid=1 expected no pending search");
            end else begin
                mon_e = q.pop_front();
                check("confirm_result", 256'(o_Confirm_Result), 256'(mon_e.cf));
                check("best_valid",     256'(o_Best_Valid),     256'(mon_e.bv));
                check("best_chan",      256'(o_Best_Chan),      256'(mon_e.ch));
                check("best_result",    256'(o_Best_Result),    256'(mon_e.br));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        k11 = {MASKWID{8'h11}};
        k22 = {MASKWID{8'h22}};
        k33 = {MASKWID{8'h33}};
        rst                  = 1'b0;
        i_Key                = '0;
        i_Valid              = 1'b0;
        i_Compare_Result     = '0;
        i_Set_Confirm_ID     = '0;
        i_Set_Confirm_String = '0;
        i_Set_Confirm_Enable = 1'b0;
        i_Set_Confirm_Op     = 1'b0;
        i_Clear_All          = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy",    256'(o_Busy),           256'(1));
        check("rst_valid",   256'(o_Valid),          256'(0));
        check("rst_bvalid",  256'(o_Best_Valid),     256'(0));
        check("rst_confirm", 256'(o_Confirm_Result), 256'(0));
        check("rst_ack",     256'(o_Set_Ack),        256'(0));
        rst = 1'b1;

        // init sweep; a set issued mid-sweep must be rejected
        c0 = cyc;
        while (o_Busy && (cyc - c0) < 400) begin
            if (cyc - c0 == 9)
                drive_set(3, k22, '0, 1, 1'b0);
            if (cyc - c0 == 10) begin
                i_Set_Confirm_Enable = 1'b0;
                check("busy_set_err", 256'(o_Set_Err), 256'(1));
                check("busy_set_ack", 256'(o_Set_Ack), 256'(0));
            end
            @(negedge clk);
        end
        i_Set_Confirm_Enable = 1'b0;
        check("init_busy_len", 256'(cyc - c0), 256'(256));
        check("init_busy_low", 256'(o_Busy), 256'(0));

        search(k22, seg_at(0, 3, 1'b1, 1'b1), mk(NO_CF, 1'b0, 0, NO_BR));

        do_set(5, k11, '0, 7, 1'b1, "set5");
        search(k11, seg_at(0, 5, 1'b1, 1'b1), mk(put(NO_CF, 0, cfv(5, 7)), 1'b1, 0, cfv(5, 7)));

        kx = k11;
        kx[7:0] = 8'hEE;
        search(kx, seg_at(0, 5, 1'b1, 1'b1), mk(NO_CF, 1'b0, 0, NO_BR));
        search(k11, seg_at(0, 5, 1'b1, 1'b0), mk(NO_CF, 1'b0, 0, NO_BR));
        do_set(5, k11, 13'h0001, 7, 1'b1, "set5m");
        search(kx, seg_at(0, 5, 1'b1, 1'b1), mk(put(NO_CF, 0, cfv(5, 7)), 1'b1, 0, cfv(5, 7)));

        do_set(3, k33, '0, 9, 1'b1, "set3");
        do_set(4, k33, '0, 9, 1'b1, "set4");
        do_set(6, k33, '0, 2, 1'b1, "set6");
        do_set(7, k33, '0, 0, 1'b1, "set7");
        search(k33, seg_at(2, 6, 1'b1, 1'b1) | seg_at(7, 4, 1'b1, 1'b1) | seg_at(12, 3, 1'b1, 1'b1),
               mk(put(put(put(NO_CF, 2, cfv(6, 2)), 7, cfv(4, 9)), 12, cfv(3, 9)), 1'b1, 7, cfv(4, 9)));
        search(k33, seg_at(1, 4, 1'b1, 1'b1) | seg_at(12, 3, 1'b1, 1'b1),
               mk(put(put(NO_CF, 1, cfv(4, 9)), 12, cfv(3, 9)), 1'b1, 1, cfv(4, 9)));
        search(k33, seg_at(5, 7, 1'b1, 1'b1), mk(put(NO_CF, 5, cfv(7, 0)), 1'b1, 5, cfv(7, 0)));
        search(k33, seg_at(0, 6, 1'b1, 1'b1) | seg_at(9, 3, 1'b1, 1'b1) | seg_at(10, 4, 1'b1, 1'b0) |
                    seg_at(11, 5, 1'b1, 1'b1) | seg_at(6, 6, 1'b0, 1'b1),
               mk(put(put(NO_CF, 0, cfv(6, 2)), 9, cfv(3, 9)), 1'b1, 9, cfv(3, 9)));

        // write and search of ID 5 on the same edge: old entry, then new
        @(negedge clk);
        drive_set(5, k11, '0, 8, 1'b0);
        issue(k11, seg_at(0, 5, 1'b1, 1'b1), mk(put(NO_CF, 0, cfv(5, 7)), 1'b1, 0, cfv(5, 7)));
        @(negedge clk);
        i_Set_Confirm_Enable = 1'b0;
        check("hazard_ack", 256'(o_Set_Ack), 256'(1));
        issue(k11, seg_at(0, 5, 1'b1, 1'b1), mk(put(NO_CF, 0, cfv(5, 8)), 1'b1, 0, cfv(5, 8)));
        @(negedge clk);
        i_Valid = 1'b0;

        do_set(0, k33, '0, 5, 1'b1, "set0");
        search(k33, seg_at(4, 0, 1'b1, 1'b1), mk(put(NO_CF, 4, cfv(0, 5)), 1'b1, 4, cfv(0, 5)));

        // back-to-back searches followed by a clear-all
        @(negedge clk);
        issue(k33, seg_at(7, 4, 1'b1, 1'b1), mk(put(NO_CF, 7, cfv(4, 9)), 1'b1, 7, cfv(4, 9)));
        @(negedge clk);
        issue(k11, seg_at(3, 5, 1'b1, 1'b1), mk(put(NO_CF, 3, cfv(5, 8)), 1'b1, 3, cfv(5, 8)));
        @(negedge clk);
        i_Valid     = 1'b0;
        i_Clear_All = 1'b1;
        c0 = cyc;
        @(negedge clk);
        i_Clear_All = 1'b0;
        check("clear_busy", 256'(o_Busy), 256'(1));
        @(negedge clk);
        issue(k33, seg_at(0, 0, 1'b1, 1'b1), mk(NO_CF, 1'b0, 0, NO_BR));
        @(negedge clk);
        i_Valid = 1'b0;
        do_set(9, k11, '0, 1, 1'b0, "clr_set");

        guard = 0;
        while (o_Busy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("clear_busy_low", 256'(o_Busy), 256'(0));
        check("clear_busy_len", 256'(cyc - c0 - 1), 256'(256));

        search(k33, seg_at(7, 4, 1'b1, 1'b1), mk(NO_CF, 1'b0, 0, NO_BR));
        do_set(8, k11, '0, 3, 1'b1, "set8");
        search(k11, seg_at(2, 8, 1'b1, 1'b1), mk(put(NO_CF, 2, cfv(8, 3)), 1'b1, 2, cfv(8, 3)));

        repeat (6) @(negedge clk);
        check("queue_drained", 256'(q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/confirm_engine_mc.md
Name: confirm_engine_mc

Overview:
- Parametrised multi-channel confirmation engine; it sits behind the segment compare stage.
- Takes NCH candidate compare results, fetches each candidate rule from a shared rule store, and confirms each against the full key under its byte mask.
- Emits per-channel confirm results plus a single best (highest-priority) match, with a valid pipeline and a self-clearing rule store.

Parameters:
- KWID, 104, key width in bits; must be a multiple of 8.
- NCH, 13, number of candidate channels.
- IDWID, 8, rule ID width.
- DEP, 1<<IDWID, rule store depth.
- PRIOR, 8, priority width.
- MASKWID, KWID/8, byte-mask width (1 bit per key byte).
- SEGWID, IDWID+2, compare-result width: [IDWID+1]=seg valid, [IDWID]=seg hit, [IDWID-1:0]=rule ID.
- CFWID, 1+IDWID+PRIOR, confirm result width: {match, rule ID, priority}.
- TOTALWID, KWID+MASKWID+PRIOR, rule string width: {key, mask, prio}, MSB to LSB.
- CHWID, $clog2(NCH), best-channel index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_Key  in  KWID  search key
- i_Valid  in  1  search strobe
- i_Compare_Result  in  NCH*SEGWID  channel c at [c*SEGWID +: SEGWID]
- o_Confirm_Result  out  NCH*CFWID  channel c at [c*CFWID +: CFWID]
- o_Valid  out  1  results valid
- o_Best_Valid  out  1  at least one channel matched
- o_Best_Chan  out  CHWID  winning channel
- o_Best_Result  out  CFWID  winning confirm result
- i_Set_Confirm_ID  in  IDWID  rule address
- i_Set_Confirm_String  in  TOTALWID  rule {key, mask, prio}
- i_Set_Confirm_Enable  in  1  set strobe
- i_Set_Confirm_Op  in  1  0 = write rule (entry valid=1), 1 = invalidate entry
- i_Clear_All  in  1  invalidate whole store
- o_Busy  out  1  INIT/CLEAR in progress
- o_Set_Ack  out  1  set accepted (1-cycle pulse)
- o_Set_Err  out  1  set dropped (1-cycle pulse)

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst=0 resets).
- Reset: all output registers 0, pipeline valids 0, FSM enters INIT, clear counter 0.
- The rule store is RAM with no reset; each entry is {entry valid, key, mask, prio}.
- FSM states: INIT, IDLE, CLEAR.
  - INIT/CLEAR: write entry valid=0 at counter address, one address per cycle, 0..DEP-1, then go to IDLE.
  - o_Busy=1 in INIT/CLEAR; the clear takes DEP cycles.
  - IDLE: i_Clear_All=1 -> CLEAR with counter=0.
  - i_Clear_All is ignored in INIT/CLEAR.
  - rst asserted mid-INIT/CLEAR restarts INIT from address 0.
- Set in IDLE:
  - The set takes effect at the clock edge where i_Set_Confirm_Enable=1.
  - o_Set_Ack pulses on the next cycle.
- Set while o_Busy=1: dropped, o_Set_Err pulses on the next cycle, store unchanged.
- Search pipeline, fixed latency 3, no backpressure; one search accepted per cycle.
  - S1: register key and segments; read rule[ID] for each channel.
  - S2: per channel, match = seg valid & seg hit & entry valid & for all bytes b: (mask[b] | key byte b == rule key byte b).
  - S3: priority reduction; all outputs registered.
- i_Valid at edge t -> o_Valid=1 at edge t+3.
- Bubbles: o_Valid=0, while the other outputs still update at latency 3. Benches sample only on o_Valid.
- Per-channel result: match=1 -> {1, ID, rule prio}; match=0 -> all zeros.
- Best match: the highest prio among matching channels; ties go to the lowest channel index.
- No channel matches: o_Best_Valid=0, o_Best_Chan=0, o_Best_Result=0.
- Read/write hazard (read-first):
  - A search in S1 at the same edge as a write to the same ID sees the old entry.
  - A search one cycle later sees the new entry.
- A search while o_Busy=1 still produces o_Valid. Entries already cleared read as invalid, so those channels give no match.
- Priority compare is unsigned, PRIOR bits; priority 0 is legal and can win.

Decomposition:
- Package confirm_pkg holds:
  - width parameters;
  - field offsets for the segment, rule string and confirm result;
  - FSM state enum {INIT, IDLE, CLEAR};
  - function byte_match(key, rkey, mask).
- Sub-module confirm_rule_ram: one write port, NCH synchronous read-first read ports (replicated banks sharing the write).
- Top level holds the FSM, set/ack logic, compare stage and reduction tree.

Test Plan:
- Reset release, no stimulus -> o_Busy=1 for exactly 256 cycles, then 0. A set at cycle 10 gives o_Set_Err=1, store unchanged.
- Write ID 5: key=0x11..11, mask=0, prio=7. Search key 0x11..11 with channel 0 seg={1,1,5} -> cycle 3: o_Confirm_Result ch0={1,5,7}, o_Best_Valid=1, o_Best_Chan=0.
- Same rule, key byte 0 changed: mask bit 0=0 gives ch0=0 and o_Best_Valid=0; mask bit 0=1 gives ch0={1,5,7}.
- Rules ID 3 prio 9, ID 4 prio 9, ID 6 prio 2; channels 2, 7, 12 hit IDs 6, 4, 3 -> o_Best_Chan=7, o_Best_Result={1,4,9}.
- Write ID 5 prio 8 and search ID 5 at the same edge -> result prio 7. Search at the next cycle -> prio 8.
- Back-to-back searches at t and t+1, plus i_Clear_All at t+2 -> two correct o_Valid results. Searches after t+3 to ID 0 report no match; o_Busy falls after 256 cycles.
